// File: rtl/ariane_pkg.sv
// Fetch-entry payload types shared between the fetch stage, the fetch FIFO and decode.
package ariane_pkg;

    localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] predict_address;
        logic        predict_taken;
        logic        valid;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Elastic buffer between instruction fetch and decode; every output comes straight from a register.
// Flush empties the queue; pushes into a full queue are dropped and latched in a sticky overflow flag.
module fetch_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  fetch_entry_t       fetch_entry_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output fetch_entry_t       fetch_entry_o,
    output logic [PTR_W:0]     count_o,
    output logic               overflow_o
);

    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_d, wr_ptr_d;
    logic [CNT_W-1:0]       count_d;
    logic [CNT_W-1:0]       remain_c;
    fetch_entry_t           head_d;
    logic                   ready_d, valid_d, overflow_d;
    logic                   push_c, pop_c;

    assign push_c = in_valid_i & in_ready_o & ~flush_i;
    assign pop_c  = out_valid_o & out_ready_i & ~flush_i;

    // Next-state: pointers, occupancy, and the head entry to present next cycle.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_o;
        head_d     = fetch_entry_o;
        remain_c   = count_o - CNT_W'(pop_c);
        overflow_d = overflow_o | (in_valid_i & ~in_ready_o & ~flush_i);

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = remain_c + CNT_W'(push_c);
            // An entry written into an otherwise empty queue becomes the head directly.
            if (push_c && (remain_c == '0)) begin
                head_d = fetch_entry_i;
            end else if (count_d != '0) begin
                head_d = mem[rd_ptr_d];
            end
        end

        ready_d = (count_d != CNT_W'(DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_o       <= '0;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            overflow_o    <= 1'b0;
            fetch_entry_o <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_o       <= count_d;
            in_ready_o    <= ready_d;
            out_valid_o   <= valid_d;
            overflow_o    <= overflow_d;
            fetch_entry_o <= head_d;
        end
    end

    // Storage is intentionally unreset; slots are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_c) mem[wr_ptr_q] <= fetch_entry_i;
    end

endmodule

// File: tb/tb_fetch_fifo.sv
// Randomized and directed stimulus for fetch_fifo, checked against a queue-based reference model.
module tb_fetch_fifo;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    fetch_entry_t fetch_entry_i;
    logic         out_valid_o;
    logic         out_ready_i;
    fetch_entry_t fetch_entry_o;
    logic [2:0]   count_o;
    logic         overflow_o;

    int checks = 0;
    int errors = 0;

    fetch_entry_t sb[$];
    logic         ovf_exp = 1'b0;

    fetch_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .fetch_entry_i (fetch_entry_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .fetch_entry_o (fetch_entry_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic fetch_entry_t mk(input logic [63:0] addr, input logic [31:0] instr);
        fetch_entry_t e;
        e = '0;
        e.address = addr;
        e.instruction = instr;
        return e;
    endfunction

    function automatic fetch_entry_t rnd_entry();
        fetch_entry_t e;
        e.address                       = {$urandom(), $urandom()};
        e.instruction                   = $urandom();
        e.branch_predict.predict_address = {$urandom(), $urandom()};
        e.branch_predict.predict_taken  = 1'($urandom_range(0, 1));
        e.branch_predict.valid          = 1'($urandom_range(0, 1));
        e.ex.cause                      = 64'($urandom_range(0, 15));
        e.ex.tval                       = {$urandom(), $urandom()};
        e.ex.valid                      = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Monitor: compare DUT against the model, then apply the upcoming edge's events to the model.
    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
            ovf_exp = 1'b0;
            check("rst_count", 512'(count_o), 512'(0));
            check("rst_valid", 512'(out_valid_o), 512'(0));
            check("rst_ready", 512'(in_ready_o), 512'(1));
            check("rst_ovf", 512'(overflow_o), 512'(0));
            check("rst_entry", 512'(fetch_entry_o), 512'(0));
        end else begin
            automatic int  n = sb.size();
            automatic logic push = in_valid_i && (n < DEPTH) && !flush_i;
            automatic logic pop  = out_ready_i && (n > 0) && !flush_i;
            check("count", 512'(count_o), 512'(n));
            check("out_valid", 512'(out_valid_o), 512'(n != 0));
            check("in_ready", 512'(in_ready_o), 512'(n != DEPTH));
            check("overflow", 512'(overflow_o), 512'(ovf_exp));
            if (n > 0) check("head", 512'(fetch_entry_o), 512'(sb[0]));
            if (in_valid_i && (n == DEPTH) && !flush_i) ovf_exp = 1'b1;
            if (flush_i) begin
                sb.delete();
            end else begin
                if (pop) void'(sb.pop_front());
                if (push) sb.push_back(fetch_entry_i);
            end
        end
    end

    task automatic cyc(input logic v, input fetch_entry_t e, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid_i    = v;
        fetch_entry_i = e;
        out_ready_i   = r;
        flush_i       = f;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("drain_timeout", 512'(sb.size()), 512'(0));
    endtask

    initial begin
        fetch_entry_t e;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; fetch_entry_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // 1: single push, visible next cycle
        cyc(1'b1, mk(64'h8000_0000, 32'h0000_0013), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain();

        // 2: fill, overflow attempt, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(64'h80 + 64'(4 * i), 32'h13), 1'b0, 1'b0);
        cyc(1'b1, mk(64'h90, 32'h13), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain();

        // 3: streaming at count 1 across pointer wraps
        cyc(1'b1, mk(64'h1000, 32'h1), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(64'h2000 + 64'(4 * i), 32'(i)), 1'b1, 1'b0);
        drain();

        // 4: full with both sides active
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(64'h3000 + 64'(4 * i), 32'h13), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(64'h4000 + 64'(4 * i), 32'h13), 1'b1, 1'b0);

        // 5: flush at count 3 with push and pop presented
        cyc(1'b1, mk(64'h5000, 32'h13), 1'b1, 1'b1);
        cyc(1'b1, mk(64'h100, 32'h13), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain();

        // 6: exception payload passthrough, then reset mid-stream
        e = mk(64'h6000, 32'h0000_0073);
        e.ex.valid = 1'b1;
        e.ex.cause = INSTR_PAGE_FAULT;
        e.ex.tval = 64'hDEAD_B000;
        e.branch_predict.valid = 1'b1;
        e.branch_predict.predict_address = 64'h2000;
        cyc(1'b1, e, 1'b0, 1'b0);
        cyc(1'b1, mk(64'h6004, 32'h13), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("ex_head_cause", 512'(fetch_entry_o.ex.cause), 512'(12));
        check("pre_rst_count", 512'(count_o), 512'(2));
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_valid", 512'(out_valid_o), 512'(0));
        check("async_rst_count", 512'(count_o), 512'(0));
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), rnd_entry(), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 31) == 0));
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_fifo.md
Name: fetch_fifo

Overview:
- Elastic buffer between the instruction-fetch stage and the decode (ID) stage.
- Stores complete ariane_pkg::fetch_entry records: address, instruction word, branchpredict_sbe hint and exception.
- Decouples fetch stalls from issue stalls and discards all in-flight fetches on a pipeline flush (mispredict, exception, fence).
- All outputs are driven from registered state. There is no combinational path from any input port to any output port.

Parameters:
- DEPTH, 4: number of entries. Power of two, at least 2.
- PTR_W, $clog2(DEPTH): read/write pointer width. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all stored entries; any push in the same cycle is dropped.
- in_valid_i  in  1  fetch stage presents an entry.
- in_ready_o  out  1  FIFO can accept an entry; equals !full.
- fetch_entry_i  in  $bits(fetch_entry)  entry from the fetch stage.
- out_valid_o  out  1  head entry is valid; equals !empty.
- out_ready_i  in  1  ID stage consumes the head entry this cycle.
- fetch_entry_o  out  $bits(fetch_entry)  head entry.
- count_o  out  PTR_W+1  number of stored entries, 0..DEPTH.
- overflow_o  out  1  sticky error flag: set when in_valid_i is high while in_ready_o is low and flush_i is low.

Behaviour:
- Reset (asynchronous assert; release on the clock edge):
  - rd_ptr = wr_ptr = 0, count_o = 0.
  - in_ready_o = 1, out_valid_o = 0, overflow_o = 0.
  - fetch_entry_o = all zero, including ex.valid = 0 and branch_predict.valid = 0.
  - Storage array is not reset. Its contents are don't-care while invalid.
- Handshakes:
  - push = in_valid_i & in_ready_o & !flush_i.
  - pop = out_valid_o & out_ready_i & !flush_i.
- Push: writes mem[wr_ptr] <= fetch_entry_i and increments wr_ptr modulo DEPTH.
- Pop: increments rd_ptr modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Output data:
  - fetch_entry_o = mem[rd_ptr] whenever out_valid_o = 1.
  - When out_valid_o = 0, fetch_entry_o holds the last value and must be ignored.
- Latency: an entry pushed in cycle N is visible on out_valid_o/fetch_entry_o in cycle N+1. There is no same-cycle bypass.
- Full (count = DEPTH):
  - in_ready_o = 0, so a push is refused even if a pop occurs in the same cycle.
  - A pop frees the slot, and in_ready_o = 1 next cycle.
- Empty (count = 0):
  - out_valid_o = 0 and pop cannot occur.
  - A push in the same cycle is accepted; the entry appears next cycle.
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance and count is unchanged. FIFO order is preserved.
- Wrap-around: pointers are PTR_W bits and wrap naturally. Full/empty are derived from count_o, never from pointer equality.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0, count_o = 0, out_valid_o = 0, in_ready_o = 1.
  - A push or pop presented in the flush cycle has no effect.
  - Flush has priority over all other events. overflow_o is not cleared by flush.
- Overflow:
  - A protocol violation, since fetch must respect ready. overflow_o is set and held until reset.
  - The offending entry is dropped and the stored data is not corrupted.
- Exceptions and branch hints are opaque payload, passed through bit-exact. An entry with ex.valid = 1 is queued and ordered like any other entry.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and any in-flight entries are lost.

Test Plan:
1. Reset with DEPTH = 4 → in_ready_o = 1, out_valid_o = 0, count_o = 0, overflow_o = 0. Then push one entry {address = 64'h8000_0000, instruction = 32'h0000_0013} with out_ready_i = 0 → next cycle out_valid_o = 1, fetch_entry_o matches exactly, count_o = 1.
2. Push 4 entries (addresses 0x80, 0x84, 0x88, 0x8C) with out_ready_i = 0 → count_o = 4, in_ready_o = 0. Then assert in_valid_i with address 0x90 → dropped, overflow_o = 1. Then pop 4 entries → addresses come out in the order 0x80, 0x84, 0x88, 0x8C.
3. Streaming: push and pop every cycle for 10 cycles from count_o = 1 → count_o stays 1 and each output trails its input by exactly one cycle. Pointers wrap twice with no loss or duplication.
4. Full with out_ready_i = 1 and in_valid_i = 1 → cycle 1: pop only, count_o 4→3. Cycle 2: in_ready_o = 1, push + pop, count_o stays 3.
5. count_o = 3 and flush_i = 1 with in_valid_i = 1 and out_ready_i = 1 in the same cycle → next cycle count_o = 0, out_valid_o = 0, in_ready_o = 1. The subsequent push of address 0x100 is the first entry out.
6. Push an entry with ex.valid = 1, cause = INSTR_PAGE_FAULT (12), tval = 64'hDEAD_B000, branch_predict.valid = 1, predict_address = 0x2000 → output fields are bit-identical. Assert rst_i mid-stream with count_o = 2 → out_valid_o drops to 0 within the same cycle, without waiting for a clock edge.
